// File: rtl/vga_timing_pkg.sv
// Shared constants for the VGA timing generator: standard display modes,
// sync polarity encoding and the pixel-divider width.
package vga_timing_pkg;

  localparam int DIV_W = 5;

  typedef enum logic {
    POL_ACTIVE_LOW  = 1'b0,
    POL_ACTIVE_HIGH = 1'b1
  } sync_pol_e;

  typedef struct packed {
    int unsigned h_visible;
    int unsigned h_front;
    int unsigned h_sync;
    int unsigned h_back;
    int unsigned v_visible;
    int unsigned v_front;
    int unsigned v_sync;
    int unsigned v_back;
    logic        h_pol;
    logic        v_pol;
  } vga_mode_t;

  localparam vga_mode_t MODE_640X480_60 = '{
    h_visible: 32'd640,  h_front: 32'd16, h_sync: 32'd96,  h_back: 32'd48,
    v_visible: 32'd480,  v_front: 32'd10, v_sync: 32'd2,   v_back: 32'd33,
    h_pol: POL_ACTIVE_LOW, v_pol: POL_ACTIVE_LOW};

  localparam vga_mode_t MODE_1024X768_60 = '{
    h_visible: 32'd1024, h_front: 32'd24, h_sync: 32'd136, h_back: 32'd160,
    v_visible: 32'd768,  v_front: 32'd3,  v_sync: 32'd6,   v_back: 32'd29,
    h_pol: POL_ACTIVE_LOW, v_pol: POL_ACTIVE_LOW};

  localparam vga_mode_t MODE_1280X1024_60 = '{
    h_visible: 32'd1280, h_front: 32'd48, h_sync: 32'd112, h_back: 32'd248,
    v_visible: 32'd1024, v_front: 32'd1,  v_sync: 32'd3,   v_back: 32'd38,
    h_pol: POL_ACTIVE_HIGH, v_pol: POL_ACTIVE_HIGH};

  // Physical pin level for a sync window state at the given polarity.
  function automatic logic sync_level(input logic active, input logic pol);
    logic level;
    if (active) begin
      level = pol;
    end else begin
      level = ~pol;
    end
    return level;
  endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Run request and timing outputs of vga_timing_gen; fetch-ahead signals exist
// only when VGA_TIMING_PREFETCH_EN is defined.
interface vga_timing_if #(
  parameter int CNT_W = 16
);
  logic             iEnable;
  logic             oHsync;
  logic             oVsync;
  logic             oActive;
  logic [CNT_W-1:0] oCol;
  logic [CNT_W-1:0] oRow;
  logic             oPixelEn;
  logic             oLineStart;
  logic             oFrameStart;
`ifdef VGA_TIMING_PREFETCH_EN
  logic [CNT_W-1:0] oFetchCol;
  logic [CNT_W-1:0] oFetchRow;
  logic             oFetchValid;
`endif

  modport master (
    input  iEnable,
`ifdef VGA_TIMING_PREFETCH_EN
    output oFetchCol, oFetchRow, oFetchValid,
`endif
    output oHsync, oVsync, oActive, oCol, oRow, oPixelEn, oLineStart, oFrameStart
  );

  modport slave (
    output iEnable,
`ifdef VGA_TIMING_PREFETCH_EN
    input  oFetchCol, oFetchRow, oFetchValid,
`endif
    input  oHsync, oVsync, oActive, oCol, oRow, oPixelEn, oLineStart, oFrameStart
  );
endinterface

// File: rtl/vga_axis_counter.sv
// One timing axis: a wrapping position counter with sync and visible window
// decodes. Used once per line (pixels) and once per frame (lines).
module vga_axis_counter #(
  parameter int CNT_W   = 16,
  parameter int VISIBLE = 640,
  parameter int FRONT   = 16,
  parameter int SYNC    = 96,
  parameter int BACK    = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             wrap,
  output logic             sync_win,
  output logic             vis_win
);
  localparam int TOTAL = VISIBLE + FRONT + SYNC + BACK;
  localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] SYNC_START = CNT_W'(VISIBLE + FRONT);
  localparam logic [CNT_W-1:0] SYNC_STOP  = CNT_W'(VISIBLE + FRONT + SYNC);
  localparam logic [CNT_W-1:0] VIS_STOP   = CNT_W'(VISIBLE);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next position: clear wins over increment, increment wraps at the last slot.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      if (count_q == LAST) begin
        count_d = '0;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end else begin
      count_d = count_q;
    end
  end

  // Position register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count    = count_q;
  assign wrap     = (count_q == LAST);
  assign sync_win = (count_q >= SYNC_START) && (count_q < SYNC_STOP);
  assign vis_win  = (count_q < VIS_STOP);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA sync/coordinate generator with a pixel-clock divider and registered,
// mutually aligned outputs. Optional fetch-ahead port: VGA_TIMING_PREFETCH_EN.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE  = int'(MODE_640X480_60.h_visible),
  parameter int H_FRONT    = int'(MODE_640X480_60.h_front),
  parameter int H_SYNC     = int'(MODE_640X480_60.h_sync),
  parameter int H_BACK     = int'(MODE_640X480_60.h_back),
  parameter int V_VISIBLE  = int'(MODE_640X480_60.v_visible),
  parameter int V_FRONT    = int'(MODE_640X480_60.v_front),
  parameter int V_SYNC     = int'(MODE_640X480_60.v_sync),
  parameter int V_BACK     = int'(MODE_640X480_60.v_back),
  parameter bit H_SYNC_POL = MODE_640X480_60.h_pol,
  parameter bit V_SYNC_POL = MODE_640X480_60.v_pol,
  parameter int PIX_DIV    = 1,
  parameter int CNT_W      = 16
`ifdef VGA_TIMING_PREFETCH_EN
  , parameter int FETCH_LEAD = 2
`endif
) (
  input logic         Clock,
  input logic         Reset,
  vga_timing_if.master bus
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

  if (H_VISIBLE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
      V_VISIBLE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_bad_geometry
    $error("vga_timing_gen: geometry parameters must be non-zero");
  end
  if (longint'(H_TOTAL) >= (longint'(1) << CNT_W) ||
      longint'(V_TOTAL) >= (longint'(1) << CNT_W)) begin : g_bad_total
    $error("vga_timing_gen: line or frame total does not fit in CNT_W bits");
  end
  if (PIX_DIV < 1 || PIX_DIV > 16) begin : g_bad_div
    $error("vga_timing_gen: PIX_DIV must be in 1..16");
  end

  logic             run_s, tick_s, adv_s;
  logic [CNT_W-1:0] h_count_s, v_count_s;
  logic             h_wrap_s, v_wrap_s, h_sync_s, v_sync_s, h_vis_s, v_vis_s;

  logic [DIV_W-1:0] div_q, div_d;
  logic             frame_arm_q, frame_arm_d;
  logic             hsync_q, hsync_d, vsync_q, vsync_d, active_q, active_d;
  logic [CNT_W-1:0] col_q, col_d, row_q, row_d;
  logic             pix_en_q, pix_en_d, line_start_q, line_start_d;
  logic             frame_start_q, frame_start_d;

  // A pixel is presented on divider phase 0 and the counters step on the last
  // phase, so oCol/oRow hold for the whole pixel starting with its strobe.
  assign run_s  = bus.iEnable;
  assign tick_s = run_s && (div_q == '0);
  assign adv_s  = run_s && (div_q == DIV_LAST);

  vga_axis_counter #(
    .CNT_W(CNT_W), .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK)
  ) u_h_cnt (
    .clk(Clock), .rst_n(Reset), .clr(!run_s), .inc(adv_s),
    .count(h_count_s), .wrap(h_wrap_s), .sync_win(h_sync_s), .vis_win(h_vis_s)
  );

  vga_axis_counter #(
    .CNT_W(CNT_W), .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK)
  ) u_v_cnt (
    .clk(Clock), .rst_n(Reset), .clr(!run_s), .inc(adv_s && h_wrap_s),
    .count(v_count_s), .wrap(v_wrap_s), .sync_win(v_sync_s), .vis_win(v_vis_s)
  );

  // Divider phase and frame-start arming; the first pixel after idle or after
  // the final pixel of a frame is a frame start.
  always_comb begin
    div_d       = div_q;
    frame_arm_d = frame_arm_q;
    if (!run_s) begin
      div_d       = '0;
      frame_arm_d = 1'b1;
    end else begin
      if (div_q == DIV_LAST) begin
        div_d = '0;
      end else begin
        div_d = div_q + DIV_W'(1);
      end
      if (adv_s && h_wrap_s && v_wrap_s) begin
        frame_arm_d = 1'b1;
      end else if (tick_s) begin
        frame_arm_d = 1'b0;
      end else begin
        frame_arm_d = frame_arm_q;
      end
    end
  end

  // Output decode of the current counters.
  always_comb begin
    hsync_d       = sync_level(1'b0, H_SYNC_POL);
    vsync_d       = sync_level(1'b0, V_SYNC_POL);
    active_d      = 1'b0;
    col_d         = '0;
    row_d         = '0;
    pix_en_d      = 1'b0;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (run_s) begin
      hsync_d       = sync_level(h_sync_s, H_SYNC_POL);
      vsync_d       = sync_level(v_sync_s, V_SYNC_POL);
      active_d      = h_vis_s && v_vis_s;
      col_d         = h_count_s;
      row_d         = v_count_s;
      pix_en_d      = tick_s;
      line_start_d  = tick_s && (h_count_s == '0);
      frame_start_d = tick_s && frame_arm_q;
    end else begin
      hsync_d       = sync_level(1'b0, H_SYNC_POL);
      vsync_d       = sync_level(1'b0, V_SYNC_POL);
      active_d      = 1'b0;
      pix_en_d      = 1'b0;
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;
    end
  end

  // Divider, arming flag and output registers.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      div_q         <= '0;
      frame_arm_q   <= 1'b1;
      hsync_q       <= ~H_SYNC_POL;
      vsync_q       <= ~V_SYNC_POL;
      active_q      <= 1'b0;
      col_q         <= '0;
      row_q         <= '0;
      pix_en_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      frame_arm_q   <= frame_arm_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      active_q      <= active_d;
      col_q         <= col_d;
      row_q         <= row_d;
      pix_en_q      <= pix_en_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.oHsync      = hsync_q;
  assign bus.oVsync      = vsync_q;
  assign bus.oActive     = active_q;
  assign bus.oCol        = col_q;
  assign bus.oRow        = row_q;
  assign bus.oPixelEn    = pix_en_q;
  assign bus.oLineStart  = line_start_q;
  assign bus.oFrameStart = frame_start_q;

`ifdef VGA_TIMING_PREFETCH_EN
  localparam int CW1 = CNT_W + 1;

  if (FETCH_LEAD < 1 || FETCH_LEAD >= H_TOTAL) begin : g_bad_lead
    $error("vga_timing_gen: FETCH_LEAD must be in 1..H_TOTAL-1");
  end

  logic [CW1-1:0]   fcol_sum_s;
  logic [CNT_W-1:0] fcol_q, fcol_d, frow_q, frow_d;
  logic             fvalid_q, fvalid_d;

  assign fcol_sum_s = {1'b0, h_count_s} + CW1'(FETCH_LEAD);

  // Coordinates FETCH_LEAD pixels ahead, carrying into the next line/frame.
  always_comb begin
    fcol_d   = '0;
    frow_d   = '0;
    fvalid_d = 1'b0;
    if (run_s) begin
      fvalid_d = 1'b1;
      if (fcol_sum_s >= CW1'(H_TOTAL)) begin
        fcol_d = CNT_W'(fcol_sum_s - CW1'(H_TOTAL));
        if (v_wrap_s) begin
          frow_d = '0;
        end else begin
          frow_d = v_count_s + CNT_W'(1);
        end
      end else begin
        fcol_d = fcol_sum_s[CNT_W-1:0];
        frow_d = v_count_s;
      end
    end else begin
      fcol_d   = '0;
      frow_d   = '0;
      fvalid_d = 1'b0;
    end
  end

  // Fetch-ahead registers, aligned with the main outputs.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      fcol_q   <= '0;
      frow_q   <= '0;
      fvalid_q <= 1'b0;
    end else begin
      fcol_q   <= fcol_d;
      frow_q   <= frow_d;
      fvalid_q <= fvalid_d;
    end
  end

  assign bus.oFetchCol   = fcol_q;
  assign bus.oFetchRow   = frow_q;
  assign bus.oFetchValid = fvalid_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen in a small mode (H 8/2/3/2, V 4/1/2/1)
// with PIX_DIV=1 (dut0) and PIX_DIV=3 (dut1).
module tb_vga_timing_gen;
  localparam int CW = 16;

  typedef struct packed {
    logic [CW-1:0] col;
    logic [CW-1:0] row;
    logic          hs;
    logic          vs;
    logic          act;
    logic          ls;
    logic          fs;
  } pix_t;

  typedef struct {
    pix_t p;
    int   gap;
  } exp_t;

  localparam pix_t IDLE = '{col: 16'd0, row: 16'd0, hs: 1'b1, vs: 1'b1,
                            act: 1'b0, ls: 1'b0, fs: 1'b0};

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  logic en0   = 1'b0;
  logic en1   = 1'b0;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  exp_t          q[2][$];
  exp_t          mon_e;
  int            last_cyc[2];
  logic [CW-1:0] last_col[2];
  bit            hold_en[2];
  bit            hold_chk[2];
  int            ls_cyc[2][$];
  int            fs_cyc[2][$];
  int            hs_low[2];
  int            vs_low[2];
  pix_t          obs[2];
  logic          pe[2];

  vga_timing_if #(.CNT_W(CW)) b0 ();
  vga_timing_if #(.CNT_W(CW)) b1 ();
  assign b0.iEnable = en0;
  assign b1.iEnable = en1;

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .PIX_DIV(1), .CNT_W(CW)
  ) dut0 (.Clock(Clock), .Reset(Reset), .bus(b0));

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .PIX_DIV(3), .CNT_W(CW)
  ) dut1 (.Clock(Clock), .Reset(Reset), .bus(b1));

  assign obs[0] = {b0.oCol, b0.oRow, b0.oHsync, b0.oVsync, b0.oActive, b0.oLineStart, b0.oFrameStart};
  assign obs[1] = {b1.oCol, b1.oRow, b1.oHsync, b1.oVsync, b1.oActive, b1.oLineStart, b1.oFrameStart};
  assign pe[0]  = b0.oPixelEn;
  assign pe[1]  = b1.oPixelEn;

  always #5 Clock = ~Clock;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected pixel k of a frame: 15 pixels/line, 8 lines/frame, hsync cols
  // 10..12, vsync rows 5..6, visible cols 0..7 x rows 0..3.
  function automatic pix_t model(input int k);
    pix_t p;
    int c, r;
    c = k % 15;
    r = (k / 15) % 8;
    p.col = CW'(c);
    p.row = CW'(r);
    p.hs  = !(c >= 10 && c <= 12);
    p.vs  = !(r >= 5 && r <= 6);
    p.act = (c < 8) && (r < 4);
    p.ls  = (c == 0);
    p.fs  = (c == 0) && (r == 0);
    return p;
  endfunction

  task automatic push(input int id, input int k0, input int k1);
    exp_t e;
    for (int k = k0; k <= k1; k++) begin
      e.p   = model(k);
      e.gap = (k == k0) ? 0 : ((id == 0) ? 1 : 3);
      q[id].push_back(e);
    end
  endtask

  // Monitor: every presented pixel is popped from the scoreboard and compared.
  always @(negedge Clock) begin
    for (int i = 0; i < 2; i++) begin
      if (!obs[i].hs) hs_low[i]++;
      if (!obs[i].vs) vs_low[i]++;
      if (pe[i]) begin
        if (q[i].size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pixel dut%0d: got col %0d row %0d, required no pixel", i, obs[i].col, obs[i].row);
        end else begin
          mon_e = q[i].pop_front();
          check($sformatf("pixel dut%0d", i), 64'(obs[i]), 64'(mon_e.p));
          if (mon_e.gap != 0) check($sformatf("pixel_gap dut%0d", i), 64'(cyc - last_cyc[i]), 64'(mon_e.gap));
          if (obs[i].ls) ls_cyc[i].push_back(cyc);
          if (obs[i].fs) fs_cyc[i].push_back(cyc);
          last_cyc[i] = cyc;
          last_col[i] = obs[i].col;
          hold_chk[i] = hold_en[i];
        end
      end else if (hold_chk[i]) begin
        check($sformatf("col_hold dut%0d", i), 64'(obs[i].col), 64'(last_col[i]));
      end
    end
  end

  task automatic check_idle(input string name, input int id);
    check($sformatf("%s outputs dut%0d", name, id), 64'(obs[id]), 64'(IDLE));
    check($sformatf("%s pixen dut%0d", name, id), 64'(pe[id]), 64'd0);
  endtask

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: got timeout, required completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      hold_en[i] = 1'b0; hold_chk[i] = 1'b0; last_cyc[i] = 0; last_col[i] = '0;
      hs_low[i] = 0; vs_low[i] = 0;
    end
    repeat (3) @(posedge Clock);
    #1;
    check_idle("reset", 0);
    check_idle("reset", 1);
    @(posedge Clock); #1 Reset = 1'b1;
    repeat (2) @(posedge Clock);
    #1;
    check_idle("enable_low", 0);
    check_idle("enable_low", 1);

    // Full frame plus one pixel on both instances.
    push(0, 0, 120);
    push(1, 0, 120);
    for (int i = 0; i < 2; i++) begin
      hs_low[i] = 0; vs_low[i] = 0;
      ls_cyc[i].delete(); fs_cyc[i].delete();
    end
    hold_en[1] = 1'b1;
    @(posedge Clock); #1;
    en0 = 1'b1;
    en1 = 1'b1;
    fork
      begin
        repeat (119) @(posedge Clock);
        #1;
        check("col_at_row7_col13", 64'(b0.oCol), 64'd13);
        check("row_at_row7_col13", 64'(b0.oRow), 64'd7);
`ifdef VGA_TIMING_PREFETCH_EN
        check("fetch_col_wrap", 64'(b0.oFetchCol), 64'd0);
        check("fetch_row_wrap", 64'(b0.oFetchRow), 64'd0);
        check("fetch_valid", 64'(b0.oFetchValid), 64'd1);
`endif
        repeat (2) @(posedge Clock);
        #1 en0 = 1'b0;
      end
      begin
        repeat (361) @(posedge Clock);
        #1;
        en1 = 1'b0;
        hold_en[1] = 1'b0;
        hold_chk[1] = 1'b0;
      end
    join
    repeat (3) @(posedge Clock);
    #1;
    check("hsync_low_clocks div1", 64'(hs_low[0]), 64'd24);
    check("vsync_low_clocks div1", 64'(vs_low[0]), 64'd30);
    check("hsync_low_clocks div3", 64'(hs_low[1]), 64'd72);
    check("vsync_low_clocks div3", 64'(vs_low[1]), 64'd90);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("line_starts dut%0d", i), 64'(ls_cyc[i].size()), 64'd9);
      check($sformatf("frame_starts dut%0d", i), 64'(fs_cyc[i].size()), 64'd2);
      if (ls_cyc[i].size() >= 2)
        check($sformatf("line_period dut%0d", i), 64'(ls_cyc[i][1] - ls_cyc[i][0]), (i == 0) ? 64'd15 : 64'd45);
      if (fs_cyc[i].size() >= 2)
        check($sformatf("frame_period dut%0d", i), 64'(fs_cyc[i][1] - fs_cyc[i][0]), (i == 0) ? 64'd120 : 64'd360);
      check($sformatf("scoreboard_empty_frame dut%0d", i), 64'(q[i].size()), 64'd0);
    end

    // Reset during hsync at row 5 col 11.
    push(0, 0, 86);
    @(posedge Clock); #1 en0 = 1'b1;
    repeat (87) @(posedge Clock);
    @(negedge Clock); #1;
    check("hsync_before_reset", 64'(b0.oHsync), 64'd0);
    check("col_before_reset", 64'(b0.oCol), 64'd11);
    Reset = 1'b0;
    #1;
    check_idle("in_reset", 0);
    repeat (3) @(posedge Clock);
    #1;
    push(0, 0, 19);
    Reset = 1'b1;
    repeat (20) @(posedge Clock);
    #1 en0 = 1'b0;
    repeat (3) @(posedge Clock);
    #1 check("scoreboard_empty_reset", 64'(q[0].size()), 64'd0);

    // Drop iEnable for 10 clocks mid-line on the divided instance.
    push(1, 0, 19);
    @(posedge Clock); #1 en1 = 1'b1;
    repeat (58) @(posedge Clock);
    #1 en1 = 1'b0;
    repeat (2) @(posedge Clock);
    #1 check_idle("disabled", 1);
    repeat (8) @(posedge Clock);
    push(1, 0, 4);
    #1 en1 = 1'b1;
    repeat (13) @(posedge Clock);
    #1 en1 = 1'b0;
    repeat (4) @(posedge Clock);
    #1;
    check("scoreboard_empty_reenable", 64'(q[1].size()), 64'd0);
    check_idle("final", 0);
    check_idle("final", 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
